fmi_ram_ctrl: RTL and testbench
===============================

Name: fmi_ram_ctrl

Overview:
Controller that sequences the FM-input tile RAM (single-port, 1-cycle synchronous read, write-first). It fills the RAM from an incoming pixel stream with sequential addressing, then hands the RAM over to the compute engine for random-access reads until released. It owns the RAM's addr/data/write pins exclusively and sits between the input DMA and the inverted-residual-block datapath.

Parameters:
N_ELEM, FMI_N_ELEM (package), RAM depth in pixels
PX_W, PX_W (package), pixel width in bits
ADDR_W, $clog2(N_ELEM), address width (derived)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  asynchronous active-high reset
start  in  1  pulse: begin loading a tile
tile_len  in  ADDR_W+1  element count for the tile, sampled on accepted start
in_valid  in  1  stream pixel valid
in_data  in  PX_W  stream pixel
in_ready  out  1  stream ready
rd_req  in  1  compute read request
rd_addr  in  ADDR_W  compute read address
rd_gnt  out  1  read accepted this cycle
rd_valid  out  1  rd_data valid (one cycle after rd_gnt)
rd_data  out  PX_W  read pixel
release  in  1  pulse: compute finished with tile
tile_ready  out  1  tile loaded, reads permitted
busy  out  1  state != IDLE
ram_addr  out  ADDR_W  to RAM addr
ram_data  out  PX_W  to RAM data
ram_write  out  1  to RAM write
ram_res  in  PX_W  from RAM res

Behaviour:
- States: IDLE, LOAD, READY. Reset -> IDLE, wr_cnt=0, len_q=0. Registered outputs reset to 0: tile_ready, rd_valid. Combinational outputs are 0 in IDLE: in_ready, rd_gnt, ram_write, ram_addr, ram_data; busy=0.
- IDLE: start=1 -> len_q<=tile_len, wr_cnt<=0; next LOAD if tile_len!=0, else READY directly. tile_len > N_ELEM is clamped to N_ELEM.
- LOAD: in_ready=1. Accept = in_valid&in_ready. On accept: ram_write=1, ram_addr=wr_cnt[ADDR_W-1:0], ram_data=in_data (all combinational, same cycle), wr_cnt<=wr_cnt+1. Accept with wr_cnt==len_q-1 -> next READY. start, rd_req and release are ignored in LOAD (rd_gnt=0).
- READY: tile_ready=1 (registered; first high the cycle after the last write edge). in_ready=0, ram_write=0 always. rd_req=1 -> rd_gnt=1, ram_addr=rd_addr combinationally; rd_valid=1 on the next cycle, rd_data=ram_res (passthrough). Back-to-back reads: one per cycle, throughput 1, latency 1. rd_addr >= len_q is still serviced (data undefined); there is no error flag.
- release in READY -> IDLE next cycle, tile_ready<=0. rd_req on the same cycle as release is still granted, and its rd_valid still fires in the following (IDLE) cycle.
- start+release on the same cycle in READY -> go straight to LOAD with new tile_len (or READY if 0). start alone in READY is ignored.
- rd_valid is 0 in every cycle not preceded by a grant. rd_data is don't-care when rd_valid=0.
- wr_cnt is ADDR_W+1 bits and never wraps: LOAD exits at len_q ≤ N_ELEM.
- Async reset mid-LOAD or mid-READY: immediate return to IDLE, counters cleared, tile_ready/rd_valid dropped asynchronously. Partial RAM contents are left as-is and are not reused.

Test Plan:
- Reset, start tile_len=4, stream 0x11,0x22,0x33,0x44 back-to-back -> ram_write high 4 cycles at addr 0..3, tile_ready=1 the cycle after the 4th write, in_ready=0 afterwards.
- Load with gaps (in_valid toggling 1,0,1,0…) tile_len=3 -> exactly 3 writes at addr 0,1,2, wr_cnt holds during gaps, READY only after the 3rd accept.
- READY, rd_req on addr 2,0,3 consecutive cycles -> rd_gnt each cycle, rd_valid next cycles with 0x33,0x11,0x44.
- READY: rd_req addr 1 with release same cycle -> rd_valid+0x22 next cycle, tile_ready=0 and busy=0 that same cycle; start+release together -> busy stays 1, state LOAD, tile_ready 0.
- start tile_len=0 -> READY next cycle with no ram_write; tile_len=N_ELEM+5 -> exactly N_ELEM writes, addr wraps never, final addr N_ELEM-1.
- Assert rst after 2 of 4 pixels -> in_ready, tile_ready, busy 0 immediately; new start tile_len=2 writes to addr 0,1.

Source files
------------

// File: rtl/fmi_ram_ctrl_if.sv
// Package constants and the bus interface shared by the FM-input tile RAM controller,
// its stream/compute clients and the RAM itself.
package fmi_ram_ctrl_pkg;
    localparam int unsigned FMI_N_ELEM = 16;
    localparam int unsigned PX_W       = 8;
endpackage

interface fmi_ram_ctrl_if #(
    parameter int unsigned N_ELEM = fmi_ram_ctrl_pkg::FMI_N_ELEM,
    parameter int unsigned PX_W   = fmi_ram_ctrl_pkg::PX_W
);
    localparam int unsigned ADDR_W = $clog2(N_ELEM);

    // tile load control and input stream
    logic              start;
    logic [ADDR_W:0]   tile_len;
    logic              in_valid;
    logic [PX_W-1:0]   in_data;
    logic              in_ready;

    // compute-side random access
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic              rd_valid;
    logic [PX_W-1:0]   rd_data;
    logic              tile_release;
    logic              tile_ready;
    logic              busy;

    // RAM pins
    logic [ADDR_W-1:0] ram_addr;
    logic [PX_W-1:0]   ram_data;
    logic              ram_write;
    logic [PX_W-1:0]   ram_res;

    modport slave (
        input  start, tile_len, in_valid, in_data,
        input  rd_req, rd_addr, tile_release, ram_res,
        output in_ready, rd_gnt, rd_valid, rd_data, tile_ready, busy,
        output ram_addr, ram_data, ram_write
    );

    modport master (
        output start, tile_len, in_valid, in_data,
        output rd_req, rd_addr, tile_release, ram_res,
        input  in_ready, rd_gnt, rd_valid, rd_data, tile_ready, busy,
        input  ram_addr, ram_data, ram_write
    );
endinterface

// File: rtl/fmi_ram_ctrl.sv
// FM-input tile RAM sequencer: fills the RAM sequentially from a pixel stream,
// then serves single-cycle-latency random reads to the compute engine until released.
module fmi_ram_ctrl #(
    parameter int unsigned N_ELEM = fmi_ram_ctrl_pkg::FMI_N_ELEM,
    parameter int unsigned PX_W   = fmi_ram_ctrl_pkg::PX_W
) (
    input  logic           clk,
    input  logic           rst,
    fmi_ram_ctrl_if.slave  bus
);
    localparam int unsigned ADDR_W = $clog2(N_ELEM);
    localparam int unsigned CNT_W  = ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             tile_ready_q, tile_ready_d;
    logic             rd_valid_q, rd_valid_d;
    logic [CNT_W-1:0] len_clamped;

    // Oversized tiles are truncated to the RAM depth so wr_cnt can never wrap.
    assign len_clamped = (bus.tile_len > CNT_W'(N_ELEM)) ? CNT_W'(N_ELEM) : bus.tile_len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wr_cnt_q     <= '0;
            len_q        <= '0;
            tile_ready_q <= 1'b0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            len_q        <= len_d;
            tile_ready_q <= tile_ready_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wr_cnt_d      = wr_cnt_q;
        len_d         = len_q;
        bus.in_ready  = 1'b0;
        bus.rd_gnt    = 1'b0;
        bus.ram_write = 1'b0;
        bus.ram_addr  = ADDR_W'(0);
        bus.ram_data  = PX_W'(0);

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    len_d    = len_clamped;
                    wr_cnt_d = '0;
                    state_d  = (len_clamped != '0) ? ST_LOAD : ST_READY;
                end
            end

            ST_LOAD: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    bus.ram_write = 1'b1;
                    bus.ram_addr  = wr_cnt_q[ADDR_W-1:0];
                    bus.ram_data  = bus.in_data;
                    wr_cnt_d      = wr_cnt_q + CNT_W'(1);
                    if (wr_cnt_q == len_q - CNT_W'(1)) begin
                        state_d = ST_READY;
                    end
                end
            end

            ST_READY: begin
                // A read issued alongside release is still honoured.
                if (bus.rd_req) begin
                    bus.rd_gnt   = 1'b1;
                    bus.ram_addr = bus.rd_addr;
                end
                if (bus.tile_release) begin
                    if (bus.start) begin
                        len_d    = len_clamped;
                        wr_cnt_d = '0;
                        state_d  = (len_clamped != '0) ? ST_LOAD : ST_READY;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        tile_ready_d = (state_d == ST_READY);
        rd_valid_d   = bus.rd_gnt;
    end

    assign bus.tile_ready = tile_ready_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_data    = bus.ram_res;
    assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fmi_ram_ctrl.sv
// Bench for fmi_ram_ctrl: vector table plus hand sequences, with write/read scoreboards
// fed by a behavioural single-port write-first RAM.
module tb_fmi_ram_ctrl;
    localparam int unsigned N  = fmi_ram_ctrl_pkg::FMI_N_ELEM;
    localparam int unsigned PW = fmi_ram_ctrl_pkg::PX_W;
    localparam int unsigned AW = $clog2(N);

    typedef struct {
        logic          st;
        logic [AW:0]   len;
        logic          iv;
        logic [PW-1:0] d;
        logic          rq;
        logic [AW-1:0] ra;
        logic          rel;
        logic          e_ir;
        logic          e_gnt;
        logic          e_wr;
        logic [AW-1:0] e_addr;
        logic          e_tr;
        logic          e_busy;
    } vec_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [PW-1:0] d;
    } wexp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_wr    = 0;
    logic [AW-1:0] last_wr_addr = '0;

    wexp_t         wq[$];
    logic [PW-1:0] rq[$];
    logic [PW-1:0] ref_mem [N];
    logic [PW-1:0] mem [N];
    logic [PW-1:0] ram_res_q;
    vec_t          tbl[$];

    fmi_ram_ctrl_if bus ();

    fmi_ram_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Single-port RAM, 1-cycle read latency, write-first
    always @(posedge clk) begin
        if (bus.ram_write) begin
            mem[bus.ram_addr] <= bus.ram_data;
            ram_res_q         <= bus.ram_data;
        end else begin
            ram_res_q <= mem[bus.ram_addr];
        end
    end
    assign bus.ram_res = ram_res_q;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [PW-1:0] d);
        wexp_t e;
        e.a = a;
        e.d = d;
        wq.push_back(e);
        ref_mem[a] = d;
    endtask

    task automatic monitor();
        wexp_t e;
        logic [PW-1:0] r;
        if (bus.ram_write === 1'b1) begin
            n_wr++;
            last_wr_addr = bus.ram_addr;
            if (wq.size() == 0) begin
                chk("unexpected_write", 32'(bus.ram_addr), 32'hFFFF_FFFF);
            end else begin
                e = wq.pop_front();
                chk("wr_addr", 32'(bus.ram_addr), 32'(e.a));
                chk("wr_data", 32'(bus.ram_data), 32'(e.d));
            end
        end
        if (bus.rd_valid === 1'b1) begin
            if (rq.size() == 0) begin
                chk("unexpected_rd_valid", 32'(bus.rd_data), 32'hFFFF_FFFF);
            end else begin
                r = rq.pop_front();
                chk("rd_data", 32'(bus.rd_data), 32'(r));
            end
        end
    endtask

    task automatic drv(input logic st, input logic [AW:0] len, input logic iv,
                       input logic [PW-1:0] d, input logic rqv, input logic [AW-1:0] ra,
                       input logic rel);
        bus.start        = st;
        bus.tile_len     = len;
        bus.in_valid     = iv;
        bus.in_data      = d;
        bus.rd_req       = rqv;
        bus.rd_addr      = ra;
        bus.tile_release = rel;
    endtask

    task automatic idle();
        drv(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic end_cyc();
        monitor();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic st, input logic [AW:0] len, input logic iv,
                                input logic [PW-1:0] d, input logic rqv, input logic [AW-1:0] ra,
                                input logic rel, input logic ir, input logic gnt, input logic wr,
                                input logic [AW-1:0] addr, input logic tr, input logic bsy);
        vec_t v;
        v.st = st; v.len = len; v.iv = iv; v.d = d; v.rq = rqv; v.ra = ra; v.rel = rel;
        v.e_ir = ir; v.e_gnt = gnt; v.e_wr = wr; v.e_addr = addr; v.e_tr = tr; v.e_busy = bsy;
        return v;
    endfunction

    initial begin
        //                st len iv d     rq ra rel  ir gnt wr addr tr busy
        tbl.push_back(mk(1, 4, 0, 8'h00, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'h11, 0, 0, 0,   1, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 8'h22, 0, 0, 0,   1, 0, 1, 1, 0, 1));
        tbl.push_back(mk(1, 9, 1, 8'h33, 1, 7, 1,   1, 0, 1, 2, 0, 1));
        tbl.push_back(mk(0, 0, 1, 8'h44, 0, 0, 0,   1, 0, 1, 3, 0, 1));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0,   0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 8'h00, 1, 2, 0,   0, 1, 0, 2, 1, 1));
        tbl.push_back(mk(0, 0, 0, 8'h00, 1, 0, 0,   0, 1, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 8'h00, 1, 3, 0,   0, 1, 0, 3, 1, 1));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0,   0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 8'h00, 1, 1, 1,   0, 1, 0, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3, 0, 8'h00, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'hA1, 0, 0, 0,   1, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 8'hEE, 0, 0, 0,   1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 8'hA2, 0, 0, 0,   1, 0, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 8'hEE, 0, 0, 0,   1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 8'hA3, 0, 0, 0,   1, 0, 1, 2, 0, 1));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0,   0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 8'h00, 1, 1, 0,   0, 1, 0, 1, 1, 1));
        tbl.push_back(mk(1, 2, 0, 8'h00, 0, 0, 0,   0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 2, 0, 8'h00, 0, 0, 1,   0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 8'hB1, 0, 0, 0,   1, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 8'hB2, 1, 5, 1,   1, 0, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0,   0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 1,   0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0,   0, 0, 0, 0, 0, 0));

        idle();
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_in_ready",   32'(bus.in_ready),   0);
        chk("rst_tile_ready", 32'(bus.tile_ready), 0);
        chk("rst_rd_valid",   32'(bus.rd_valid),   0);
        chk("rst_busy",       32'(bus.busy),       0);
        chk("rst_ram_write",  32'(bus.ram_write),  0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table-driven main function
        foreach (tbl[i]) begin
            drv(tbl[i].st, tbl[i].len, tbl[i].iv, tbl[i].d, tbl[i].rq, tbl[i].ra, tbl[i].rel);
            if (tbl[i].e_wr) push_wr(tbl[i].e_addr, tbl[i].d);
            if (tbl[i].e_gnt) rq.push_back(ref_mem[tbl[i].ra]);
            @(negedge clk);
            chk($sformatf("v%0d_in_ready", i),   32'(bus.in_ready),   32'(tbl[i].e_ir));
            chk($sformatf("v%0d_rd_gnt", i),     32'(bus.rd_gnt),     32'(tbl[i].e_gnt));
            chk($sformatf("v%0d_ram_write", i),  32'(bus.ram_write),  32'(tbl[i].e_wr));
            chk($sformatf("v%0d_ram_addr", i),   32'(bus.ram_addr),   32'(tbl[i].e_addr));
            chk($sformatf("v%0d_tile_ready", i), 32'(bus.tile_ready), 32'(tbl[i].e_tr));
            chk($sformatf("v%0d_busy", i),       32'(bus.busy),       32'(tbl[i].e_busy));
            end_cyc();
        end
        idle();

        // Zero-length tile goes straight to READY without writing
        drv(1'b1, '0, 1'b0, '0, 1'b0, '0, 1'b0);
        @(negedge clk);
        end_cyc();
        idle();
        @(negedge clk);
        chk("zero_tile_ready", 32'(bus.tile_ready), 1);
        chk("zero_busy",       32'(bus.busy),       1);
        chk("zero_ram_write",  32'(bus.ram_write),  0);
        end_cyc();
        drv(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
        @(negedge clk);
        end_cyc();
        idle();
        @(negedge clk);
        chk("zero_rel_busy", 32'(bus.busy), 0);
        end_cyc();

        // Oversized tile is clamped to the RAM depth
        drv(1'b1, (AW + 1)'(N + 5), 1'b0, '0, 1'b0, '0, 1'b0);
        @(negedge clk);
        end_cyc();
        n_wr = 0;
        for (int i = 0; i < N + 5; i++) begin
            drv(1'b0, '0, 1'b1, PW'(8'h40 + i), 1'b0, '0, 1'b0);
            if (i < N) push_wr(AW'(i), PW'(8'h40 + i));
            @(negedge clk);
            chk($sformatf("clamp%0d_in_ready", i), 32'(bus.in_ready), (i < N) ? 1 : 0);
            end_cyc();
        end
        idle();
        @(negedge clk);
        chk("clamp_writes",     32'(n_wr),         32'(N));
        chk("clamp_last_addr",  32'(last_wr_addr), 32'(N - 1));
        chk("clamp_tile_ready", 32'(bus.tile_ready), 1);
        end_cyc();
        drv(1'b0, '0, 1'b0, '0, 1'b1, AW'(N - 1), 1'b1);
        rq.push_back(ref_mem[N-1]);
        @(negedge clk);
        end_cyc();
        idle();
        @(negedge clk);
        end_cyc();

        // Asynchronous reset in the middle of a load
        drv(1'b1, 4, 1'b0, '0, 1'b0, '0, 1'b0);
        @(negedge clk);
        end_cyc();
        for (int i = 0; i < 2; i++) begin
            drv(1'b0, '0, 1'b1, PW'(8'hC0 + i), 1'b0, '0, 1'b0);
            push_wr(AW'(i), PW'(8'hC0 + i));
            @(negedge clk);
            end_cyc();
        end
        drv(1'b0, '0, 1'b1, 8'hC2, 1'b0, '0, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_load_in_ready",   32'(bus.in_ready),   0);
        chk("arst_load_tile_ready", 32'(bus.tile_ready), 0);
        chk("arst_load_busy",       32'(bus.busy),       0);
        chk("arst_load_ram_write",  32'(bus.ram_write),  0);
        idle();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        drv(1'b1, 2, 1'b0, '0, 1'b0, '0, 1'b0);
        @(negedge clk);
        end_cyc();
        n_wr = 0;
        for (int i = 0; i < 2; i++) begin
            drv(1'b0, '0, 1'b1, PW'(8'hD0 + i), 1'b0, '0, 1'b0);
            push_wr(AW'(i), PW'(8'hD0 + i));
            @(negedge clk);
            end_cyc();
        end
        idle();
        @(negedge clk);
        chk("reload_writes",     32'(n_wr),           2);
        chk("reload_last_addr",  32'(last_wr_addr),   1);
        chk("reload_tile_ready", 32'(bus.tile_ready), 1);
        end_cyc();

        // Asynchronous reset drops a pending rd_valid
        drv(1'b0, '0, 1'b0, '0, 1'b1, 0, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1;
        idle();
        chk("arst_rd_valid_before", 32'(bus.rd_valid), 1);
        chk("arst_rd_data_before",  32'(bus.rd_data),  32'(8'hD0));
        rst = 1'b1;
        #1;
        chk("arst_rd_valid",   32'(bus.rd_valid),   0);
        chk("arst_tile_ready", 32'(bus.tile_ready), 0);
        chk("arst_busy",       32'(bus.busy),       0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        chk("wq_drained", 32'(wq.size()), 0);
        chk("rq_drained", 32'(rq.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
